gs_latch_packer: RTL

//  Upstream stage of the TLC LED-driver serializer. Accepts an 8-bit-per-colour RGB pixel stream,

---
 rtl/gs_latch_packer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/gs_latch_packer.sv
// Packs 24-bit RGB pixels, 16 per word, into ping-pong buffered 769-bit grayscale latch words.
// Latency: 16th pixel accepted in cycle n -> word_valid in cycle n+1 when the output side is idle.
// Backpressure: pix_ready drops only while both buffers hold complete words awaiting word_ready.
module gs_latch_packer #(
  parameter int NUM_DRIVERS_CHAINED = 2,
  parameter bit EXPAND              = 1'b1,
  localparam int DW = (NUM_DRIVERS_CHAINED > 1) ? $clog2(NUM_DRIVERS_CHAINED) : 1
) (
  input  logic          TESTCLK,
  input  logic          nReset,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic          pix_sof,
  input  logic [23:0]   pix_rgb,
  output logic          word_valid,
  input  logic          word_ready,
  output logic [768:0]  word_data,
  output logic [DW-1:0] word_drv,
  output logic          word_last,
  output logic          sof_err
);

  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_FILLING = 2'd1,
    BUF_FULL    = 2'd2
  } buf_state_e;

  buf_state_e     state_q [2];
  buf_state_e     state_d [2];
  logic [767:0]   data_q  [2];
  logic [DW-1:0]  tag_q   [2];
  logic [3:0]     ch_cnt_q, ch_cnt_d;
  logic [DW-1:0]  drv_cnt_q, drv_cnt_d;
  logic           wr_sel_q, wr_sel_d;
  logic           rd_sel_q, rd_sel_d;
  logic           sof_err_q, sof_err_d;

  logic [1:0]     full_cnt;
  logic           accept, restart, complete, word_hs;
  logic [3:0]     ch_eff;
  logic [DW-1:0]  drv_eff;
  logic [9:0]     slot_base;
  logic [47:0]    pix_gs;

  // Bit-level 8->16 grayscale expansion: replicate the byte or pad with zeros.
  function automatic logic [15:0] expand8(input logic [7:0] c);
    return EXPAND ? {c, c} : {c, 8'h00};
  endfunction

  // Output decode: handshake readiness and the word presented from the read-side buffer.
  always_comb begin
    full_cnt   = {1'b0, state_q[0] == BUF_FULL} + {1'b0, state_q[1] == BUF_FULL};
    pix_ready  = (full_cnt != 2'd2);
    word_valid = (state_q[rd_sel_q] == BUF_FULL);
    word_data  = {1'b0, data_q[rd_sel_q]};
    word_drv   = tag_q[rd_sel_q];
    word_last  = word_valid & (word_drv == DW'(NUM_DRIVERS_CHAINED - 1));
    sof_err    = sof_err_q;
  end

  // Pixel qualification: an out-of-place sof restarts the word as channel 0 of driver 0.
  always_comb begin
    accept    = pix_valid & pix_ready;
    restart   = accept & pix_sof & ((ch_cnt_q != 4'd0) | (drv_cnt_q != '0));
    ch_eff    = restart ? 4'd0 : ch_cnt_q;
    drv_eff   = restart ? '0 : drv_cnt_q;
    complete  = accept & (ch_eff == 4'd15);
    word_hs   = word_valid & word_ready;
    slot_base = {6'd0, ch_eff} * 10'd48;
    pix_gs    = {expand8(pix_rgb[7:0]), expand8(pix_rgb[15:8]), expand8(pix_rgb[23:16])};
  end

  // Buffer FSM next state: write side fills/completes, read side empties on handshake.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      if (accept && (wr_sel_q == 1'(b)))
        state_d[b] = complete ? BUF_FULL : BUF_FILLING;
      if (word_hs && (rd_sel_q == 1'(b)))
        state_d[b] = BUF_EMPTY;
    end
  end

  // Channel/driver counters and buffer selectors; the 4-bit channel count wraps 15->0 on completion.
  always_comb begin
    ch_cnt_d  = ch_cnt_q;
    drv_cnt_d = drv_cnt_q;
    wr_sel_d  = wr_sel_q;
    rd_sel_d  = rd_sel_q ^ word_hs;
    sof_err_d = accept & pix_sof & (ch_cnt_q != 4'd0);
    if (accept) begin
      ch_cnt_d  = ch_eff + 4'd1;
      drv_cnt_d = drv_eff;
      if (complete) begin
        wr_sel_d  = ~wr_sel_q;
        drv_cnt_d = (drv_eff == DW'(NUM_DRIVERS_CHAINED - 1)) ? '0 : drv_eff + DW'(1);
      end
    end
  end

  // Control state registers.
  always_ff @(posedge TESTCLK or negedge nReset) begin
    if (!nReset) begin
      state_q[0] <= BUF_EMPTY;
      state_q[1] <= BUF_EMPTY;
      ch_cnt_q   <= 4'd0;
      drv_cnt_q  <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      sof_err_q  <= 1'b0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      ch_cnt_q   <= ch_cnt_d;
      drv_cnt_q  <= drv_cnt_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      sof_err_q  <= sof_err_d;
    end
  end

  // Word storage: each accepted pixel lands in its 48-bit slot; the driver tag is captured on completion.
  always_ff @(posedge TESTCLK or negedge nReset) begin
    if (!nReset) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      tag_q[0]  <= '0;
      tag_q[1]  <= '0;
    end else if (accept) begin
      data_q[wr_sel_q][slot_base +: 48] <= pix_gs;
      if (complete)
        tag_q[wr_sel_q] <= drv_eff;
    end
  end

endmodule
